// File: rtl/bbox_sample_iter.sv
`default_nettype none
// ============================================================================
// Module   : bbox_sample_iter
// Summary  : Raster-walks the sample grid of a triangle's bounding box, one
//            sample per cycle. Optional macro: SAMPLE_ITER_BACK2BACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bbox_sample_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                          validTri_R13H,
  input  logic        [3:0]                             subSample_RnnnnU,
  output logic                                          halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
  output logic                                          validSamp_R14H
);

  typedef enum logic [0:0] {
    WAIT_STATE = 1'b0,
    TEST_STATE = 1'b1
  } state_t;

  localparam logic [SIGFIG:0] c_one = (SIGFIG+1)'(1);

  state_t              r_state;
  logic [SIGFIG-1:0]   r_ll_x;
  logic [SIGFIG-1:0]   r_ur_x;
  logic [SIGFIG-1:0]   r_ur_y;
  logic [SIGFIG:0]     r_step;

  logic [SIGFIG:0]     w_step;
  logic [SIGFIG:0]     w_next_x;
  logic [SIGFIG:0]     w_next_y;
  logic                w_x_over;
  logic                w_y_over;
  logic                w_last;
  logic                w_accept;
  logic                w_empty;

  always_comb begin
    w_step = c_one << RADIX;
    case (subSample_RnnnnU)
      4'b1000: w_step = c_one << RADIX;
      4'b0100: w_step = c_one << (RADIX - 1);
      4'b0010: w_step = c_one << (RADIX - 2);
      4'b0001: w_step = c_one << (RADIX - 3);
      default: w_step = c_one << RADIX;
    endcase
  end

  // One guard bit so stepping past the most positive coordinate cannot wrap.
  assign w_next_x = {sample_R14S[0][SIGFIG-1], sample_R14S[0]} + r_step;
  assign w_next_y = {sample_R14S[1][SIGFIG-1], sample_R14S[1]} + r_step;
  assign w_x_over = $signed(w_next_x) > $signed({r_ur_x[SIGFIG-1], r_ur_x});
  assign w_y_over = $signed(w_next_y) > $signed({r_ur_y[SIGFIG-1], r_ur_y});
  assign w_last   = (r_state == TEST_STATE) && w_x_over && w_y_over;

`ifdef SAMPLE_ITER_BACK2BACK_EN
  assign halt_RnnnnL = (r_state == WAIT_STATE) || w_last;
`else
  assign halt_RnnnnL = (r_state == WAIT_STATE);
`endif

  assign w_accept = validTri_R13H && halt_RnnnnL;
  assign w_empty  = ($signed(box_R13S[1][0]) < $signed(box_R13S[0][0])) ||
                    ($signed(box_R13S[1][1]) < $signed(box_R13S[0][1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= WAIT_STATE;
      r_ll_x         <= '0;
      r_ur_x         <= '0;
      r_ur_y         <= '0;
      r_step         <= '0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= 1'b0;
    end else if (w_accept && !w_empty) begin
      r_state        <= TEST_STATE;
      r_ll_x         <= box_R13S[0][0];
      r_ur_x         <= box_R13S[1][0];
      r_ur_y         <= box_R13S[1][1];
      r_step         <= w_step;
      tri_R14S       <= tri_R13S;
      color_R14U     <= color_R13U;
      sample_R14S[0] <= box_R13S[0][0];
      sample_R14S[1] <= box_R13S[0][1];
      validSamp_R14H <= 1'b1;
    end else if (r_state == TEST_STATE) begin
      if (w_last) begin
        r_state        <= WAIT_STATE;
        validSamp_R14H <= 1'b0;
      end else if (w_x_over) begin
        sample_R14S[0] <= r_ll_x;
        sample_R14S[1] <= w_next_y[SIGFIG-1:0];
      end else begin
        sample_R14S[0] <= w_next_x[SIGFIG-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bbox_sample_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbox_sample_iter
// Summary  : Scoreboard bench for bbox_sample_iter (optionally with
//            SAMPLE_ITER_BACK2BACK_EN defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bbox_sample_iter;

  localparam int S = 24;

  typedef struct {
    logic [S-1:0]           x;
    logic [S-1:0]           y;
    logic [2:0][2:0][S-1:0] tri_v;
    logic [2:0][S-1:0]      col;
    bit                     last;
  } exp_t;

  logic                          clk;
  logic                          rst;
  logic signed [2:0][2:0][S-1:0] tri_in;
  logic        [2:0][S-1:0]      col_in;
  logic signed [1:0][1:0][S-1:0] box_in;
  logic                          valid_tri;
  logic        [3:0]             sub;
  logic                          halt;
  logic signed [2:0][2:0][S-1:0] tri_out;
  logic        [2:0][S-1:0]      col_out;
  logic signed [1:0][S-1:0]      samp;
  logic                          valid_samp;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  bbox_sample_iter dut (
    .clk             (clk),
    .rst             (rst),
    .tri_R13S        (tri_in),
    .color_R13U      (col_in),
    .box_R13S        (box_in),
    .validTri_R13H   (valid_tri),
    .subSample_RnnnnU(sub),
    .halt_RnnnnL     (halt),
    .tri_R14S        (tri_out),
    .color_R14U      (col_out),
    .sample_R14S     (samp),
    .validSamp_R14H  (valid_samp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic monitor();
    exp_t e;
    logic exp_halt;
    forever begin
      @(negedge clk);
      if (!rst && valid_samp) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample: got x=%0d y=%0d, required no sample",
                   $signed(samp[0]), $signed(samp[1]));
        end else begin
          e = q.pop_front();
          checks++;
          if (samp[0] !== e.x) begin
            errors++;
            $display("FAIL sample_x: got %0d, required %0d", $signed(samp[0]), $signed(e.x));
          end
          checks++;
          if (samp[1] !== e.y) begin
            errors++;
            $display("FAIL sample_y: got %0d, required %0d", $signed(samp[1]), $signed(e.y));
          end
          checks++;
          if (tri_out !== e.tri_v) begin
            errors++;
            $display("FAIL held_tri: got %h, required %h", tri_out, e.tri_v);
          end
          checks++;
          if (col_out !== e.col) begin
            errors++;
            $display("FAIL held_color: got %h, required %h", col_out, e.col);
          end
`ifdef SAMPLE_ITER_BACK2BACK_EN
          exp_halt = e.last;
`else
          exp_halt = 1'b0;
`endif
          checks++;
          if (halt !== exp_halt) begin
            errors++;
            $display("FAIL halt_during_walk: got %b, required %b", halt, exp_halt);
          end
        end
      end
    end
  endtask

  function automatic int step_of(input logic [3:0] s);
    case (s)
      4'b0100: return 512;
      4'b0010: return 256;
      4'b0001: return 128;
      default: return 1024;
    endcase
  endfunction

  // Called in the cycle after a rising edge; returns just after the accept edge.
  task automatic offer(input int llx, input int lly, input int urx, input int ury,
                       input logic [3:0] s);
    exp_t e;
    bit   got;
    int   st;
    int   n;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) tri_in[v][a] = S'($urandom());
    for (int c = 0; c < 3; c++) col_in[c] = S'($urandom());
    box_in[0][0] = S'(llx);
    box_in[0][1] = S'(lly);
    box_in[1][0] = S'(urx);
    box_in[1][1] = S'(ury);
    sub       = s;
    valid_tri = 1'b1;
    got       = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (halt) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: halt stayed 0, required 1 within 60 cycles");
    end else begin
      st = step_of(s);
      n  = 0;
      for (int y = lly; y <= ury; y += st)
        for (int x = llx; x <= urx; x += st) begin
          e.x     = S'(x);
          e.y     = S'(y);
          e.tri_v = tri_in;
          e.col   = col_in;
          e.last  = 1'b0;
          q.push_back(e);
          n++;
        end
      if (n > 0) begin
        e = q.pop_back();
        e.last = 1'b1;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    valid_tri = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d samples outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b0) begin
      errors++;
      $display("FAIL valid_after_last: got %b, required 0", valid_samp);
    end
    checks++;
    if (halt !== 1'b1) begin
      errors++;
      $display("FAIL halt_after_last: got %b, required 1", halt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (valid_samp !== 1'b0 || samp !== '0 || tri_out !== '0 || col_out !== '0) begin
      errors++;
      $display("FAIL %s: got valid=%b sample=%h tri=%h color=%h, required all 0",
               tag, valid_samp, samp, tri_out, col_out);
    end
    checks++;
    if (halt !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt: got %b, required 1", tag, halt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_values");
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_1x();
    offer(0, 0, 1024, 1024, 4'b1000);
    drain();
  endtask

  task automatic test_subsample();
    offer(0, 0, 512, 256, 4'b0010);
    drain();
    offer(-512, -256, -256, 0, 4'b0001);
    drain();
    offer(0, 0, 1024, 0, 4'b0110);
    drain();
  endtask

  task automatic test_degenerate();
    offer(-2048, 3072, -2048, 3072, 4'b1000);
    drain();
  endtask

  task automatic test_empty();
    offer(1024, 0, 0, 0, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (valid_samp !== 1'b0 || halt !== 1'b1) begin
        errors++;
        $display("FAIL empty_box: got valid=%b halt=%b, required valid=0 halt=1",
                 valid_samp, halt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    offer(8388608 - 3072, 0, 8388608 - 1024, 1024, 4'b1000);
    drain();
  endtask

  task automatic test_reset_mid();
    offer(0, 0, 1024, 1024, 4'b1000);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid_walk");
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (valid_samp !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_idle: got valid=%b, required 0", valid_samp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [9:0] pat;
    logic [9:0] exp_pat;
    bit         seen;
`ifdef SAMPLE_ITER_BACK2BACK_EN
    exp_pat = 10'b1111111100;
`else
    exp_pat = 10'b1111011110;
`endif
    pat  = '0;
    seen = 1'b0;
    fork
      begin
        offer(0, 0, 1024, 1024, 4'b1000);
        offer(2048, 2048, 3072, 3072, 4'b1000);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (valid_samp) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          pat[9] = 1'b1;
          for (int k = 8; k >= 0; k--) begin
            @(negedge clk);
            pat[k] = valid_samp;
          end
        end
      end
    join
    checks++;
    if (pat !== exp_pat) begin
      errors++;
      $display("FAIL back_to_back_pattern: got %b, required %b", pat, exp_pat);
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    tri_in    = '0;
    col_in    = '0;
    box_in    = '0;
    valid_tri = 1'b0;
    sub       = 4'b1000;
    fork
      monitor();
    join_none
    test_reset();
    test_basic_1x();
    test_subsample();
    test_degenerate();
    test_empty();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
